// File: rtl/if_stage.sv
// Instruction fetch: registered PC, direct-mapped one-word icache, 2-bit BHT branch prediction.
// Latency: hit is combinational on the registered PC; a miss costs 4 byte handshakes + 1 cycle.
// Backpressure: stall freezes the PC (fills still run); stallreq_o flags an unavailable instruction.
module if_stage #(
    parameter int          ICACHE_IDX_W = 6,
    parameter int          BHT_IDX_W    = 7,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  stall,
    output logic        stallreq_o,
    input  logic        branch_error,
    input  logic [31:0] branch_target_i,
    input  logic        bht_we_i,
    input  logic [31:0] bht_pc_i,
    input  logic        bht_taken_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ready_i,
    input  logic [7:0]  mem_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        predict_result_o,
    output logic [31:0] next_pc_o
);

    localparam int          LINES      = 1 << ICACHE_IDX_W;
    localparam int          TAG_W      = 30 - ICACHE_IDX_W;
    localparam int          BHT_N      = 1 << BHT_IDX_W;
    // Stall bus encoding: 00 pass, 01 hold, 10 bubble; only pass lets the PC advance.
    localparam logic [1:0]  STALL_PASS = 2'b00;
    localparam logic [6:0]  OP_JAL     = 7'b1101111;
    localparam logic [6:0]  OP_BRANCH  = 7'b1100011;

    typedef enum logic {S_IDLE, S_FILL} state_t;

    logic [31:0]             r_pc;
    logic                    r_valid [LINES];
    logic [TAG_W-1:0]        r_tag   [LINES];
    logic [31:0]             r_data  [LINES];
    logic [1:0]              r_bht   [BHT_N];
    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [1:0]              r_cnt;
    logic [23:0]             r_buf;

    logic [ICACHE_IDX_W-1:0] w_idx;
    logic [TAG_W-1:0]        w_tag;
    logic                    w_hit;
    logic [31:0]             w_inst;
    logic [BHT_IDX_W-1:0]    w_bht_idx;
    logic [BHT_IDX_W-1:0]    w_upd_idx;
    logic [31:0]             w_j_imm;
    logic [31:0]             w_b_imm;
    logic                    w_pred;
    logic [31:0]             w_npc;
    logic                    w_fill_done;
    logic [31-BHT_IDX_W:0]   w_unused_bht_pc;

    assign w_idx     = r_pc[ICACHE_IDX_W+1:2];
    assign w_tag     = r_pc[31:ICACHE_IDX_W+2];
    assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_inst    = w_hit ? r_data[w_idx] : 32'h0;
    assign w_bht_idx = r_pc[BHT_IDX_W+1:2];
    assign w_upd_idx = bht_pc_i[BHT_IDX_W+1:2];
    assign w_j_imm   = {{12{w_inst[31]}}, w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
    assign w_b_imm   = {{20{w_inst[31]}}, w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
    // Last byte accepted without a concurrent redirect completes the line.
    assign w_fill_done = (r_state == S_FILL) && mem_ready_i && !branch_error && (r_cnt == 2'd3);
    assign w_unused_bht_pc = {bht_pc_i[31:BHT_IDX_W+2], bht_pc_i[1:0]};

    // Static prediction for JAL, BHT-driven for conditional branches, fall-through otherwise.
    always_comb begin
        w_pred = 1'b0;
        w_npc  = 32'h0;
        if (w_hit) begin
            w_npc = r_pc + 32'd4;
            case (w_inst[6:0])
                OP_JAL: begin
                    w_pred = 1'b1;
                    w_npc  = r_pc + w_j_imm;
                end
                OP_BRANCH: begin
                    if (r_bht[w_bht_idx][1]) begin
                        w_pred = 1'b1;
                        w_npc  = r_pc + w_b_imm;
                    end
                end
                default: ;
            endcase
        end
    end

    // PC: redirect beats sequential advance; advance only on a hit with the stage passing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc <= RESET_PC;
        end else if (branch_error) begin
            r_pc <= branch_target_i;
        end else if ((stall == STALL_PASS) && w_hit) begin
            r_pc <= w_npc;
        end
    end

    // Fill FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Fill FSM next state: start on a miss unless redirecting, leave on last byte or redirect.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (!w_hit && !branch_error) w_state_nxt = S_FILL;
            S_FILL:  if (branch_error || (mem_ready_i && (r_cnt == 2'd3))) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Fill FSM outputs and the combinational lookup results toward IF/ID.
    always_comb begin
        mem_req_o        = (r_state == S_FILL);
        mem_addr_o       = (r_state == S_FILL) ? (r_pc + {30'h0, r_cnt}) : 32'h0;
        stallreq_o       = !w_hit;
        pc_o             = r_pc;
        inst_o           = w_inst;
        predict_result_o = w_pred;
        next_pc_o        = w_npc;
    end

    // Byte counter and little-endian assembly of the first three bytes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= 2'd0;
            r_buf <= 24'h0;
        end else if (r_state == S_IDLE) begin
            r_cnt <= 2'd0;
        end else if (mem_ready_i && !branch_error) begin
            case (r_cnt)
                2'd0:    r_buf[7:0]   <= mem_data_i;
                2'd1:    r_buf[15:8]  <= mem_data_i;
                2'd2:    r_buf[23:16] <= mem_data_i;
                default: ;
            endcase
            r_cnt <= r_cnt + 2'd1;
        end
    end

    // Valid bits: cleared by reset, set when a fill completes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < LINES; i++) r_valid[i] <= 1'b0;
        end else if (w_fill_done) begin
            r_valid[w_idx] <= 1'b1;
        end
    end

    // Tag and data storage: written only by a completed fill, never by a reset-abandoned one.
    always_ff @(posedge clk) begin
        if (rst && w_fill_done) begin
            r_tag[w_idx]  <= w_tag;
            r_data[w_idx] <= {mem_data_i, r_buf};
        end
    end

    // BHT: 2-bit saturating counters, weakly not-taken after reset; lookups see the pre-update value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < BHT_N; i++) r_bht[i] <= 2'b01;
        end else if (bht_we_i) begin
            if (bht_taken_i) begin
                if (r_bht[w_upd_idx] != 2'b11) r_bht[w_upd_idx] <= r_bht[w_upd_idx] + 2'b01;
            end else begin
                if (r_bht[w_upd_idx] != 2'b00) r_bht[w_upd_idx] <= r_bht[w_upd_idx] - 2'b01;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: byte-memory responder, address and fetch scoreboards.
// Latency of a miss, prediction, BHT saturation, aborts and aliasing are all checked.
// Outputs are sampled 1 time unit after the rising edge, inputs driven at the same point.
module tb_if_stage;

    localparam logic [1:0] PASS = 2'b00;
    localparam logic [1:0] HOLD = 2'b01;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred;
        logic [31:0] npc;
    } fetch_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  stall;
    logic        stallreq_o;
    logic        branch_error;
    logic [31:0] branch_target_i;
    logic        bht_we_i;
    logic [31:0] bht_pc_i;
    logic        bht_taken_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ready_i;
    logic [7:0]  mem_data_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        predict_result_o;
    logic [31:0] next_pc_o;

    logic [7:0]  mem [0:1023];
    logic [31:0] exp_addr_q [$];
    fetch_t      exp_fetch_q [$];
    logic        auto_mem;
    int          n_pass = 0;
    int          n_total = 0;
    int          lat;
    logic [10:0] tseq;
    logic [10:0] pseq;
    logic        prev_pred;

    if_stage dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .stallreq_o       (stallreq_o),
        .branch_error     (branch_error),
        .branch_target_i  (branch_target_i),
        .bht_we_i         (bht_we_i),
        .bht_pc_i         (bht_pc_i),
        .bht_taken_i      (bht_taken_i),
        .mem_req_o        (mem_req_o),
        .mem_addr_o       (mem_addr_o),
        .mem_ready_i      (mem_ready_i),
        .mem_data_i       (mem_data_i),
        .pc_o             (pc_o),
        .inst_o           (inst_o),
        .predict_result_o (predict_result_o),
        .next_pc_o        (next_pc_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic write_word(input int addr, input logic [31:0] w);
        for (int b = 0; b < 4; b++) mem[addr + b] = w[8*b +: 8];
    endtask

    task automatic push_fill(input logic [31:0] base, input int nbytes);
        for (int b = 0; b < nbytes; b++) exp_addr_q.push_back(base + b);
    endtask

    task automatic push_fetch(input logic [31:0] pc, input logic [31:0] inst,
                              input logic pred, input logic [31:0] npc);
        fetch_t f;
        f.pc = pc; f.inst = inst; f.pred = pred; f.npc = npc;
        exp_fetch_q.push_back(f);
    endtask

    // One clock: after the edge, answer any pending byte request and score its address.
    task automatic tick();
        logic [31:0] exp_a;
        @(posedge clk);
        #1;
        mem_ready_i = 1'b0;
        mem_data_i  = 8'h00;
        if (auto_mem && mem_req_o) begin
            exp_a = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : 32'hFFFF_FFFF;
            chk("mem_addr", mem_addr_o, exp_a);
            mem_ready_i = 1'b1;
            mem_data_i  = mem[mem_addr_o[9:0]];
        end
    endtask

    task automatic redirect(input logic [31:0] t);
        branch_error    = 1'b1;
        branch_target_i = t;
        tick();
        branch_error    = 1'b0;
    endtask

    task automatic wait_hit(output int n);
        n = 0;
        while (stallreq_o && n < 40) begin
            tick();
            n++;
        end
        chk("hit_timeout", {31'h0, stallreq_o}, 32'h0);
    endtask

    task automatic check_fetch(input string tag);
        fetch_t f;
        f = exp_fetch_q.pop_front();
        chk({tag, "_pc"},   pc_o, f.pc);
        chk({tag, "_inst"}, inst_o, f.inst);
        chk({tag, "_pred"}, {31'h0, predict_result_o}, {31'h0, f.pred});
        chk({tag, "_npc"},  next_pc_o, f.npc);
    endtask

    initial begin
        rst = 1'b0; stall = HOLD; branch_error = 1'b0; branch_target_i = 32'h0;
        bht_we_i = 1'b0; bht_pc_i = 32'h0; bht_taken_i = 1'b0;
        mem_ready_i = 1'b0; mem_data_i = 8'h00; auto_mem = 1'b1;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        write_word(32'h000, 32'h0000_0013);
        write_word(32'h100, 32'h0010_0113);

        // Reset state
        repeat (3) tick();
        chk("rst_mem_req",  {31'h0, mem_req_o}, 32'h0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_stallreq", {31'h0, stallreq_o}, 32'h1);
        chk("rst_pc",       pc_o, 32'h0);
        chk("rst_inst",     inst_o, 32'h0);
        chk("rst_npc",      next_pc_o, 32'h0);

        // First fill at 0: four byte reads, hit one cycle after the last
        push_fill(32'h0, 4);
        push_fetch(32'h0, 32'h0000_0013, 1'b0, 32'h4);
        rst = 1'b1;
        wait_hit(lat);
        chk("miss_latency", lat, 32'd5);
        check_fetch("addi0");

        // Aliasing: 0x100 shares index 0 with 0x0
        redirect(32'h100);
        chk("alias_miss", {31'h0, stallreq_o}, 32'h1);
        push_fill(32'h100, 4);
        push_fetch(32'h100, 32'h0010_0113, 1'b0, 32'h104);
        wait_hit(lat);
        check_fetch("alias100");
        write_word(32'h000, 32'h0080_006f);
        redirect(32'h0);
        chk("return_miss", {31'h0, stallreq_o}, 32'h1);
        push_fill(32'h0, 4);
        push_fetch(32'h0, 32'h0080_006f, 1'b1, 32'h8);
        wait_hit(lat);
        check_fetch("jal0");

        // JAL advance under pass: next PC 8 misses and fills from 8
        write_word(32'h008, 32'h0000_0013);
        push_fill(32'h8, 4);
        push_fetch(32'h8, 32'h0000_0013, 1'b0, 32'hC);
        stall = PASS;
        tick();
        stall = HOLD;
        chk("jal_pc", pc_o, 32'h8);
        chk("jal_target_miss", {31'h0, stallreq_o}, 32'h1);
        wait_hit(lat);
        check_fetch("at8");

        // BEQ -16 at 0x10: BHT training and saturation at both ends
        write_word(32'h010, 32'hFE00_08E3);
        redirect(32'h10);
        push_fill(32'h10, 4);
        push_fetch(32'h10, 32'hFE00_08E3, 1'b0, 32'h14);
        wait_hit(lat);
        check_fetch("beq_init");
        tseq = 11'b11_000_000_111;   // bit i = outcome of update i (LSB first)
        pseq = 11'b10_000_001_111;   // bit i = prediction after update i
        prev_pred = 1'b0;
        for (int i = 0; i < 11; i++) begin
            bht_we_i    = 1'b1;
            bht_pc_i    = 32'h10;
            bht_taken_i = tseq[i];
            chk("bht_same_cycle", {31'h0, predict_result_o}, {31'h0, prev_pred});
            tick();
            bht_we_i = 1'b0;
            chk("bht_pred", {31'h0, predict_result_o}, {31'h0, pseq[i]});
            chk("bht_npc",  next_pc_o, pseq[i] ? 32'h0 : 32'h14);
            prev_pred = pseq[i];
        end

        // Hold at 0x20 for three cycles, then release
        write_word(32'h020, 32'h0010_0093);
        write_word(32'h024, 32'h0000_8067);
        redirect(32'h20);
        push_fill(32'h20, 4);
        push_fetch(32'h20, 32'h0010_0093, 1'b0, 32'h24);
        wait_hit(lat);
        check_fetch("at20");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_pc",   pc_o, 32'h20);
            chk("hold_inst", inst_o, 32'h0010_0093);
        end
        push_fill(32'h24, 2);
        stall = PASS;
        tick();
        stall = HOLD;
        chk("release_pc", pc_o, 32'h24);
        chk("release_miss_inst", inst_o, 32'h0);

        // Abort after two bytes; the third byte's ready is ignored
        tick();
        tick();
        auto_mem = 1'b0;
        tick();
        chk("third_req",  {31'h0, mem_req_o}, 32'h1);
        chk("third_addr", mem_addr_o, 32'h26);
        mem_ready_i = 1'b1;
        mem_data_i  = mem[32'h26];
        redirect(32'h40);
        chk("abort_req_drop", {31'h0, mem_req_o}, 32'h0);
        chk("abort_pc", pc_o, 32'h40);
        auto_mem = 1'b1;
        write_word(32'h040, 32'hFC1F_F06F);
        push_fill(32'h40, 4);
        push_fetch(32'h40, 32'hFC1F_F06F, 1'b1, 32'h0);
        wait_hit(lat);
        check_fetch("jal_back");
        redirect(32'h24);
        chk("aborted_line_invalid", {31'h0, stallreq_o}, 32'h1);
        chk("miss_pred", {31'h0, predict_result_o}, 32'h0);
        chk("miss_npc",  next_pc_o, 32'h0);
        push_fill(32'h24, 4);
        push_fetch(32'h24, 32'h0000_8067, 1'b0, 32'h28);
        wait_hit(lat);
        check_fetch("jalr");

        // Reset mid-fill abandons the fill and clears the cache
        write_word(32'h030, 32'h0000_0013);
        redirect(32'h30);
        push_fill(32'h30, 1);
        tick();
        auto_mem = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("midrst_req",  {31'h0, mem_req_o}, 32'h0);
        chk("midrst_addr", mem_addr_o, 32'h0);
        chk("midrst_pc",   pc_o, 32'h0);
        chk("midrst_cache_cleared", {31'h0, stallreq_o}, 32'h1);
        rst = 1'b1;
        redirect(32'h30);
        chk("midrst_line_discarded", {31'h0, stallreq_o}, 32'h1);

        chk("addr_queue_empty",  exp_addr_q.size(), 32'h0);
        chk("fetch_queue_empty", exp_fetch_q.size(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
